// File: rtl/lib_pow2_sched.sv
// Drains each accepted request vector as a sequence of beats, each beat carrying
// up to LANES one-hot grants taken from the residual bits in priority order.
module lib_pow2_sched #(
    parameter int WIDTH   = 8,
    parameter int LANES   = 2,
    parameter int LSB_MSB = 0
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [WIDTH-1:0]           s_vect,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [LANES*WIDTH-1:0]     m_onehot,
    output logic [LANES-1:0]           m_lane_vld,
    output logic                       m_last,
    output logic [$clog2(WIDTH+1)-1:0] m_beat
);

    localparam int BW = $clog2(WIDTH+1);
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [BW-1:0]    BEAT_ONE = {{(BW-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] rem_reg, rem_next;
    logic [BW-1:0]    beat_reg, beat_next;

    // Residual bits reordered so the highest-priority bit is always bit 0.
    logic [WIDTH-1:0] rem_ord;
    logic [WIDTH-1:0] mask [LANES+1];
    logic [WIDTH-1:0] lane_ord [LANES];
    logic [WIDTH-1:0] lane_nat [LANES];
    logic [WIDTH-1:0] grant_or;

    genvar gi, gj;
    generate
        for (gj = 0; gj < WIDTH; gj++) begin : g_ord
            if (LSB_MSB != 0) begin : g_rev
                assign rem_ord[gj] = rem_reg[WIDTH-1-gj];
            end else begin : g_fwd
                assign rem_ord[gj] = rem_reg[gj];
            end
        end

        assign mask[0] = rem_ord;
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            // Isolate lowest set bit, then strip it for the next lane.
            assign lane_ord[gi] = mask[gi] & (~mask[gi] + ONE);
            assign mask[gi+1]   = mask[gi] & ~lane_ord[gi];
            for (gj = 0; gj < WIDTH; gj++) begin : g_bit
                if (LSB_MSB != 0) begin : g_rev
                    assign lane_nat[gi][gj] = lane_ord[gi][WIDTH-1-gj];
                end else begin : g_fwd
                    assign lane_nat[gi][gj] = lane_ord[gi][gj];
                end
            end
            assign m_onehot[gi*WIDTH +: WIDTH] = m_valid ? lane_nat[gi] : '0;
            assign m_lane_vld[gi]              = m_valid & (|lane_nat[gi]);
        end
    endgenerate

    always_comb begin
        grant_or = '0;
        for (int i = 0; i < LANES; i++) begin
            grant_or = grant_or | lane_nat[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= IDLE;
            rem_reg   <= '0;
            beat_reg  <= '0;
        end else begin
            state_reg <= state_next;
            rem_reg   <= rem_next;
            beat_reg  <= beat_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        rem_next   = rem_reg;
        beat_next  = beat_reg;
        m_valid    = rstn && (state_reg == BUSY);
        // Last beat once this beat's grants exhaust the residual bits.
        m_last     = m_valid && (mask[LANES] == '0);
        m_beat     = m_valid ? beat_reg : '0;
        s_ready    = rstn && ((state_reg == IDLE) || (m_last && m_ready));

        case (state_reg)
            IDLE: begin
                if (s_valid) begin
                    rem_next   = s_vect;
                    beat_next  = '0;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (m_ready) begin
                    if (!m_last) begin
                        rem_next  = rem_reg & ~grant_or;
                        beat_next = beat_reg + BEAT_ONE;
                    end else if (s_valid) begin
                        rem_next  = s_vect;
                        beat_next = '0;
                    end else begin
                        rem_next   = '0;
                        beat_next  = '0;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lib_pow2_sched.sv
// Directed bench for lib_pow2_sched: an LSB-first instance for most cases and
// an MSB-first instance for the priority-reversal case.
module tb_lib_pow2_sched;

    localparam int WIDTH = 8;
    localparam int LANES = 2;
    localparam int BW    = $clog2(WIDTH+1);

    logic clk = 1'b0;
    logic rstn;

    logic                   s_valid, s_ready, m_valid, m_ready, m_last;
    logic [WIDTH-1:0]       s_vect;
    logic [LANES*WIDTH-1:0] m_onehot;
    logic [LANES-1:0]       m_lane_vld;
    logic [BW-1:0]          m_beat;

    logic                   s_valid2, s_ready2, m_valid2, m_ready2, m_last2;
    logic [WIDTH-1:0]       s_vect2;
    logic [LANES*WIDTH-1:0] m_onehot2;
    logic [LANES-1:0]       m_lane_vld2;
    logic [BW-1:0]          m_beat2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lib_pow2_sched #(.WIDTH(WIDTH), .LANES(LANES), .LSB_MSB(0)) dut (
        .clk(clk), .rstn(rstn),
        .s_valid(s_valid), .s_ready(s_ready), .s_vect(s_vect),
        .m_valid(m_valid), .m_ready(m_ready), .m_onehot(m_onehot),
        .m_lane_vld(m_lane_vld), .m_last(m_last), .m_beat(m_beat)
    );

    lib_pow2_sched #(.WIDTH(WIDTH), .LANES(LANES), .LSB_MSB(1)) dut_msb (
        .clk(clk), .rstn(rstn),
        .s_valid(s_valid2), .s_ready(s_ready2), .s_vect(s_vect2),
        .m_valid(m_valid2), .m_ready(m_ready2), .m_onehot(m_onehot2),
        .m_lane_vld(m_lane_vld2), .m_last(m_last2), .m_beat(m_beat2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full beat check on the LSB-first instance, one line per beat.
    task automatic beat_chk(input string tag, input logic ev, input logic [15:0] eoh,
                            input logic [1:0] evld, input logic elast,
                            input logic [BW-1:0] ebeat, input logic esr);
        $display("%s: m_valid=%0b onehot=%04h vld=%02b last=%0b beat=%0d s_ready=%0b",
                 tag, m_valid, m_onehot, m_lane_vld, m_last, m_beat, s_ready);
        chk({tag, ".m_valid"},    32'(m_valid),    32'(ev));
        chk({tag, ".m_onehot"},   32'(m_onehot),   32'(eoh));
        chk({tag, ".m_lane_vld"}, 32'(m_lane_vld), 32'(evld));
        chk({tag, ".m_last"},     32'(m_last),     32'(elast));
        chk({tag, ".m_beat"},     32'(m_beat),     32'(ebeat));
        chk({tag, ".s_ready"},    32'(s_ready),    32'(esr));
    endtask

    task automatic beat_chk2(input string tag, input logic [15:0] eoh,
                             input logic elast, input logic [BW-1:0] ebeat);
        $display("%s: m_valid=%0b onehot=%04h vld=%02b last=%0b beat=%0d",
                 tag, m_valid2, m_onehot2, m_lane_vld2, m_last2, m_beat2);
        chk({tag, ".m_valid"},    32'(m_valid2),    32'd1);
        chk({tag, ".m_onehot"},   32'(m_onehot2),   32'(eoh));
        chk({tag, ".m_lane_vld"}, 32'(m_lane_vld2), 32'b11);
        chk({tag, ".m_last"},     32'(m_last2),     32'(elast));
        chk({tag, ".m_beat"},     32'(m_beat2),     32'(ebeat));
    endtask

    initial begin
        rstn = 1'b0; s_valid = 1'b0; s_vect = '0; m_ready = 1'b1;
        s_valid2 = 1'b0; s_vect2 = '0; m_ready2 = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        beat_chk("reset", 1'b0, 16'h0000, 2'b00, 1'b0, 0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("post_reset.s_ready", 32'(s_ready), 32'd1);

        // 1: 8'hB6 -> three beats
        s_valid = 1'b1; s_vect = 8'hB6;
        @(negedge clk); s_valid = 1'b0; #1;
        beat_chk("t1.b0", 1'b1, 16'h0402, 2'b11, 1'b0, 0, 1'b0);
        @(negedge clk); #1;
        beat_chk("t1.b1", 1'b1, 16'h2010, 2'b11, 1'b0, 1, 1'b0);
        @(negedge clk); #1;
        beat_chk("t1.b2", 1'b1, 16'h0080, 2'b01, 1'b1, 2, 1'b1);
        @(negedge clk); #1;
        beat_chk("t1.idle", 1'b0, 16'h0000, 2'b00, 1'b0, 0, 1'b1);

        // 2: zero vector -> single empty last beat
        s_valid = 1'b1; s_vect = 8'h00;
        @(negedge clk); s_valid = 1'b0; #1;
        beat_chk("t2.b0", 1'b1, 16'h0000, 2'b00, 1'b1, 0, 1'b1);
        @(negedge clk); #1;
        beat_chk("t2.idle", 1'b0, 16'h0000, 2'b00, 1'b0, 0, 1'b1);

        // 3: backpressure holds beat0 of 8'hF0
        s_valid = 1'b1; s_vect = 8'hF0; m_ready = 1'b0;
        @(negedge clk); s_valid = 1'b0; #1;
        beat_chk("t3.hold0", 1'b1, 16'h2010, 2'b11, 1'b0, 0, 1'b0);
        @(negedge clk); #1;
        beat_chk("t3.hold1", 1'b1, 16'h2010, 2'b11, 1'b0, 0, 1'b0);
        @(negedge clk); #1;
        beat_chk("t3.hold2", 1'b1, 16'h2010, 2'b11, 1'b0, 0, 1'b0);
        @(negedge clk); m_ready = 1'b1; #1;
        beat_chk("t3.b0", 1'b1, 16'h2010, 2'b11, 1'b0, 0, 1'b0);
        @(negedge clk); #1;
        beat_chk("t3.b1", 1'b1, 16'h8040, 2'b11, 1'b1, 1, 1'b1);
        @(negedge clk); #1;
        beat_chk("t3.idle", 1'b0, 16'h0000, 2'b00, 1'b0, 0, 1'b1);

        // 4: back-to-back vectors with no idle cycle
        s_valid = 1'b1; s_vect = 8'h03;
        @(negedge clk); s_vect = 8'h0C; #1;
        beat_chk("t4.v0", 1'b1, 16'h0201, 2'b11, 1'b1, 0, 1'b1);
        @(negedge clk); s_valid = 1'b0; #1;
        beat_chk("t4.v1", 1'b1, 16'h0804, 2'b11, 1'b1, 0, 1'b1);
        @(negedge clk); #1;
        beat_chk("t4.idle", 1'b0, 16'h0000, 2'b00, 1'b0, 0, 1'b1);

        // 6: reset mid-vector
        s_valid = 1'b1; s_vect = 8'hFF;
        @(negedge clk); s_valid = 1'b0; #1;
        beat_chk("t6.b0", 1'b1, 16'h0201, 2'b11, 1'b0, 0, 1'b0);
        @(negedge clk); #1;
        beat_chk("t6.b1", 1'b1, 16'h0804, 2'b11, 1'b0, 1, 1'b0);
        rstn = 1'b0;
        @(negedge clk); #1;
        beat_chk("t6.rst", 1'b0, 16'h0000, 2'b00, 1'b0, 0, 1'b0);
        rstn = 1'b1;
        @(negedge clk); #1;
        beat_chk("t6.rel", 1'b0, 16'h0000, 2'b00, 1'b0, 0, 1'b1);
        s_valid = 1'b1; s_vect = 8'h01;
        @(negedge clk); s_valid = 1'b0; #1;
        beat_chk("t6.new", 1'b1, 16'h0001, 2'b01, 1'b1, 0, 1'b1);

        // 5: MSB-first priority on the second instance
        chk("t5.s_ready_idle", 32'(s_ready2), 32'd1);
        s_valid2 = 1'b1; s_vect2 = 8'hFF;
        @(negedge clk); s_valid2 = 1'b0; #1;
        beat_chk2("t5.b0", 16'h4080, 1'b0, 0);
        @(negedge clk); #1;
        beat_chk2("t5.b1", 16'h1020, 1'b0, 1);
        @(negedge clk); #1;
        beat_chk2("t5.b2", 16'h0408, 1'b0, 2);
        @(negedge clk); #1;
        beat_chk2("t5.b3", 16'h0102, 1'b1, 3);
        @(negedge clk); #1;
        chk("t5.idle.m_valid", 32'(m_valid2), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
